// File: rtl/uart_rx_frame_checker_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART RX frame checker.
//               Parity mode encodings, FSM state type, the minimum legal
//               frame length and the expected-parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  // Parity mode encodings as seen on cfg_par_mode
  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  // Shortest frame accepted; shorter requests fall back to DATA_WIDTH
  localparam int MIN_DATA_BITS = 5;

  // Frame checker FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } state_t;

  // Reserved mode codes 5..7 behave exactly like "no parity"
  function automatic logic [2:0] norm_par_mode(input logic [2:0] mode);
    return (mode > PAR_SPACE) ? PAR_NONE : mode;
  endfunction

  // Parity bit the transmitter should have sent, given the running XOR
  function automatic logic exp_par_bit(input logic [2:0] mode, input logic acc);
    logic bit_val;
    bit_val = 1'b0;
    case (mode)
      PAR_EVEN:  bit_val = acc;
      PAR_ODD:   bit_val = ~acc;
      PAR_MARK:  bit_val = 1'b1;
      PAR_SPACE: bit_val = 1'b0;
      default:   bit_val = 1'b0;
    endcase
    return bit_val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_frame_checker_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Saturating event counter. clr alone zeroes the count, clr
//               together with inc loads 1, inc alone counts up and sticks
//               at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  // Count events; clear has priority but still records a same-cycle event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? WIDTH'(1) : '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame_checker.sv
// ============================================================================
// Module      : uart_rx_frame_checker
// Description : Deserialises one UART frame from the bit sampler, checks
//               parity (none/even/odd/mark/space) and one or two stop bits,
//               emits per-frame status pulses and keeps saturating error
//               counters. Optional sticky status outputs are built when
//               UART_RX_STICKY_STATUS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame_checker
  import uart_rx_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int CNT_WIDTH  = 8,
  localparam int DLW        = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_start,
  input  logic [DLW-1:0]        cfg_data_bits,
  input  logic [2:0]            cfg_par_mode,
  input  logic                  cfg_stop2,
  input  logic                  sampled_bit,
  input  logic                  sample_valid,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt,
  output logic                  busy
`ifdef UART_RX_STICKY_STATUS_EN
  ,
  output logic                  sticky_par_err,
  output logic                  sticky_stp_err
`endif
);

  localparam int IDXW = $clog2(DATA_WIDTH);

  state_t         state;
  logic [DLW-1:0] bit_cnt;
  logic [DLW-1:0] data_bits;
  logic [2:0]     par_mode;
  logic           stop2;
  logic           par_acc;
  logic           par_flag;
  logic           stp_flag;
  logic [DLW-1:0] data_bits_clamped;
  logic           last_data_bit;

  // Out-of-range frame lengths fall back to the full data width
  always_comb begin
    data_bits_clamped = cfg_data_bits;
    if ((cfg_data_bits < DLW'(MIN_DATA_BITS)) || (cfg_data_bits > DLW'(DATA_WIDTH))) begin
      data_bits_clamped = DLW'(DATA_WIDTH);
    end
  end

  assign last_data_bit = (bit_cnt == (data_bits - DLW'(1)));
  assign busy          = (state != ST_IDLE);

  // Frame FSM: deserialise, accumulate parity, check stop bits, pulse status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      p_data     <= '0;
      bit_cnt    <= '0;
      data_bits  <= '0;
      par_mode   <= PAR_NONE;
      stop2      <= 1'b0;
      par_acc    <= 1'b0;
      par_flag   <= 1'b0;
      stp_flag   <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (frame_start) begin
        // Also aborts any frame in flight; a coincident sample is dropped
        state     <= ST_DATA;
        p_data    <= '0;
        bit_cnt   <= '0;
        par_acc   <= 1'b0;
        par_flag  <= 1'b0;
        stp_flag  <= 1'b0;
        data_bits <= data_bits_clamped;
        par_mode  <= norm_par_mode(cfg_par_mode);
        stop2     <= cfg_stop2;
      end else if (sample_valid) begin
        case (state)
          ST_DATA: begin
            p_data[bit_cnt[IDXW-1:0]] <= sampled_bit;
            par_acc                   <= par_acc ^ sampled_bit;
            bit_cnt                   <= bit_cnt + DLW'(1);
            if (last_data_bit) begin
              state <= (par_mode == PAR_NONE) ? ST_STOP1 : ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_flag <= (sampled_bit != exp_par_bit(par_mode, par_acc));
            state    <= ST_STOP1;
          end
          ST_STOP1: begin
            stp_flag <= ~sampled_bit;
            if (stop2) begin
              state <= ST_STOP2;
            end else begin
              data_valid <= 1'b1;
              par_err    <= par_flag;
              stp_err    <= ~sampled_bit;
              state      <= ST_IDLE;
            end
          end
          ST_STOP2: begin
            data_valid <= 1'b1;
            par_err    <= par_flag;
            stp_err    <= stp_flag | ~sampled_bit;
            state      <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_par_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (par_err),
    .clr     (err_clr),
    .cnt     (par_err_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stp_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stp_err),
    .clr     (err_clr),
    .cnt     (stp_err_cnt)
  );

`ifdef UART_RX_STICKY_STATUS_EN
  // Sticky flags: an error pulse sets, err_clr clears, set wins on a tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_par_err <= 1'b0;
      sticky_stp_err <= 1'b0;
    end else begin
      if (par_err) begin
        sticky_par_err <= 1'b1;
      end else if (err_clr) begin
        sticky_par_err <= 1'b0;
      end
      if (stp_err) begin
        sticky_stp_err <= 1'b1;
      end else if (err_clr) begin
        sticky_stp_err <= 1'b0;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame_checker.sv
// ============================================================================
// Module      : tb_uart_rx_frame_checker
// Description : Directed self-checking bench for uart_rx_frame_checker
//               (DATA_WIDTH=8, CNT_WIDTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frame_checker;

  localparam int DW  = 8;
  localparam int CW  = 2;
  localparam int DLW = $clog2(DW) + 1;

  logic           clk;
  logic           reset_n;
  logic           frame_start;
  logic [DLW-1:0] cfg_data_bits;
  logic [2:0]     cfg_par_mode;
  logic           cfg_stop2;
  logic           sampled_bit;
  logic           sample_valid;
  logic           err_clr;
  logic [DW-1:0]  p_data;
  logic           data_valid;
  logic           par_err;
  logic           stp_err;
  logic [CW-1:0]  par_err_cnt;
  logic [CW-1:0]  stp_err_cnt;
  logic           busy;
`ifdef UART_RX_STICKY_STATUS_EN
  logic           sticky_par_err;
  logic           sticky_stp_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  uart_rx_frame_checker #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_start   (frame_start),
    .cfg_data_bits (cfg_data_bits),
    .cfg_par_mode  (cfg_par_mode),
    .cfg_stop2     (cfg_stop2),
    .sampled_bit   (sampled_bit),
    .sample_valid  (sample_valid),
    .err_clr       (err_clr),
    .p_data        (p_data),
    .data_valid    (data_valid),
    .par_err       (par_err),
    .stp_err       (stp_err),
    .par_err_cnt   (par_err_cnt),
    .stp_err_cnt   (stp_err_cnt),
    .busy          (busy)
`ifdef UART_RX_STICKY_STATUS_EN
    ,
    .sticky_par_err (sticky_par_err),
    .sticky_stp_err (sticky_stp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left just after a falling edge
  task automatic start_frame(input int nbits, input logic [2:0] mode, input logic s2);
    frame_start   = 1'b1;
    cfg_data_bits = DLW'(nbits);
    cfg_par_mode  = mode;
    cfg_stop2     = s2;
    @(negedge clk);
    frame_start   = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sampled_bit  = b;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_data(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) send_bit(d[i]);
  endtask

  // Final sample: the status pulse is visible right after the consuming edge
  task automatic last_bit(input string tag, input logic b, input logic [DW-1:0] exp_data,
                          input logic exp_pe, input logic exp_se, input logic clr);
    chk({tag, "_dv_early"}, 32'(data_valid), 32'd0);
    sampled_bit  = b;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    err_clr      = clr;
    chk({tag, "_dv"},    32'(data_valid), 32'd1);
    chk({tag, "_data"},  32'(p_data),     32'(exp_data));
    chk({tag, "_pe"},    32'(par_err),    32'(exp_pe));
    chk({tag, "_se"},    32'(stp_err),    32'(exp_se));
    chk({tag, "_busy"},  32'(busy),       32'd0);
    @(negedge clk);
    err_clr = 1'b0;
    chk({tag, "_dv_off"}, 32'(data_valid), 32'd0);
    chk({tag, "_hold"},   32'(p_data),     32'(exp_data));
  endtask

  initial begin
    reset_n       = 1'b0;
    frame_start   = 1'b0;
    cfg_data_bits = '0;
    cfg_par_mode  = 3'd0;
    cfg_stop2     = 1'b0;
    sampled_bit   = 1'b1;
    sample_valid  = 1'b0;
    err_clr       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(p_data),      32'd0);
    chk("rst_dv",   32'(data_valid),  32'd0);
    chk("rst_busy", 32'(busy),        32'd0);
    chk("rst_pcnt", 32'(par_err_cnt), 32'd0);
    chk("rst_scnt", 32'(stp_err_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Samples in IDLE are ignored
    send_bit(1'b0);
    chk("idle_busy", 32'(busy), 32'd0);

    // 8N1, 0xA5
    start_frame(8, 3'd0, 1'b0);
    chk("f1_busy", 32'(busy), 32'd1);
    send_data(16'h00A5, 8);
    last_bit("f1", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);

    // 8E1, 0x07 (three ones -> parity bit 1), wrong parity 0
    start_frame(8, 3'd1, 1'b0);
    send_data(16'h0007, 8);
    send_bit(1'b0);
    last_bit("f2a", 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    chk("f2a_pcnt", 32'(par_err_cnt), 32'd1);
`ifdef UART_RX_STICKY_STATUS_EN
    chk("f2a_sticky", 32'(sticky_par_err), 32'd1);
`endif
    // Same frame with correct parity 1
    start_frame(8, 3'd1, 1'b0);
    send_data(16'h0007, 8);
    send_bit(1'b1);
    last_bit("f2b", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    chk("f2b_pcnt", 32'(par_err_cnt), 32'd1);

    // 5O2, 0x1F (five ones -> odd parity bit 0), stops 1 then 0
    start_frame(5, 3'd2, 1'b1);
    send_data(16'h001F, 5);
    send_bit(1'b0);
    send_bit(1'b1);
    last_bit("f3", 1'b0, 8'h1F, 1'b0, 1'b1, 1'b0);
    chk("f3_scnt", 32'(stp_err_cnt), 32'd1);
    chk("f3_pcnt", 32'(par_err_cnt), 32'd1);

    // Mark: parity bit 1 is correct
    start_frame(8, 3'd3, 1'b0);
    send_data(16'h0007, 8);
    send_bit(1'b1);
    last_bit("mark", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    // Space: parity bit 1 is an error
    start_frame(8, 3'd4, 1'b0);
    send_data(16'h0007, 8);
    send_bit(1'b1);
    last_bit("space", 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    chk("space_pcnt", 32'(par_err_cnt), 32'd2);

    // Abort after 4 bits; restart coincides with a dropped sample of 1
    start_frame(8, 3'd1, 1'b0);
    send_data(16'h000F, 4);
    sampled_bit  = 1'b1;
    sample_valid = 1'b1;
    start_frame(8, 3'd0, 1'b0);
    sample_valid = 1'b0;
    chk("abort_dv",   32'(data_valid), 32'd0);
    chk("abort_busy", 32'(busy),       32'd1);
    chk("abort_clr",  32'(p_data),     32'd0);
    @(negedge clk);
    send_data(16'h003C, 8);
    last_bit("abort", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("abort_pcnt", 32'(par_err_cnt), 32'd2);
    chk("abort_scnt", 32'(stp_err_cnt), 32'd1);

    // Length 3 clamps to 8, mode 7 behaves as no parity
    start_frame(3, 3'd7, 1'b0);
    send_data(16'h0081, 8);
    last_bit("clamp", 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);

    // Parity errors 3 and 4: counter saturates at 3
    start_frame(8, 3'd1, 1'b0);
    send_data(16'h0007, 8);
    send_bit(1'b0);
    last_bit("sat3", 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    chk("sat3_pcnt", 32'(par_err_cnt), 32'd3);
    start_frame(8, 3'd1, 1'b0);
    send_data(16'h0007, 8);
    send_bit(1'b0);
    last_bit("sat4", 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    chk("sat4_pcnt", 32'(par_err_cnt), 32'd3);
    // Error 5 with err_clr in the pulse cycle -> 1; stop counter cleared -> 0
    start_frame(8, 3'd1, 1'b0);
    send_data(16'h0007, 8);
    send_bit(1'b0);
    last_bit("sat5", 1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    chk("sat5_pcnt", 32'(par_err_cnt), 32'd1);
    chk("sat5_scnt", 32'(stp_err_cnt), 32'd0);

    // Async reset mid-frame discards it
    start_frame(8, 3'd0, 1'b0);
    send_data(16'h00FF, 3);
    reset_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy),   32'd0);
    chk("mrst_data", 32'(p_data), 32'd0);
    chk("mrst_pcnt", 32'(par_err_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mrst_dv", 32'(data_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
- Parametrised successor to the UART RX parity check stage; sits between the RX bit sampler and the RX FSM/output register.
- Consumes the sampled bit stream of one frame, from the bit after the start bit to the last stop bit.
- Deserialises the data, computes parity on the fly, and checks parity in five modes plus one or two stop bits.
- Reports per-frame status pulses and keeps saturating error counters for the register block.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame (legal 5..16)
CNT_WIDTH, 8, width of each error counter
DLW, $clog2(DATA_WIDTH)+1, width of cfg_data_bits (derived, not overridden)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse when the start bit is accepted
cfg_data_bits  in  DLW  data bits per frame, sampled at frame_start
cfg_par_mode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space; 5..7 treated as none
cfg_stop2  in  1  1 = two stop bits expected
sampled_bit  in  1  sampled line value
sample_valid  in  1  one-cycle strobe; sampled_bit valid
err_clr  in  1  clears both error counters
p_data  out  DATA_WIDTH  received data, LSB first, zero-extended
data_valid  out  1  one-cycle pulse at frame completion
par_err  out  1  one-cycle pulse, coincident with data_valid
stp_err  out  1  one-cycle pulse, coincident with data_valid
par_err_cnt  out  CNT_WIDTH  saturating parity-error count
stp_err_cnt  out  CNT_WIDTH  saturating stop-error count
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: async on reset_n low.
  - State goes to IDLE.
  - Every output, the shift register, bit counter, running parity and latched config are cleared to 0.
  - Reset mid-frame discards the frame; no pulses are produced.
- Config latch:
  - cfg_* are captured on frame_start and ignored at all other times.
  - cfg_data_bits < 5 or > DATA_WIDTH is clamped to DATA_WIDTH.
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - frame_start moves to DATA.
  - On entry, p_data, bit_cnt and running parity clear to 0.
  - sample_valid is ignored in IDLE.
- DATA, on each sample_valid:
  - p_data[bit_cnt] <= sampled_bit; par_acc ^= sampled_bit; bit_cnt++.
  - After bit index data_bits-1: go to PARITY if mode is even/odd/mark/space, else to STOP1.
- PARITY, on sample_valid:
  - Expected bit: even = par_acc, odd = ~par_acc, mark = 1, space = 0.
  - par_flag = (sampled_bit != expected).
  - Go to STOP1.
- STOP1, on sample_valid:
  - stp_flag = (sampled_bit == 0).
  - If stop2 go to STOP2, else complete.
- STOP2, on sample_valid:
  - stp_flag |= (sampled_bit == 0).
  - Complete.
- Complete:
  - In the cycle after the final sample_valid: data_valid=1, par_err=par_flag, stp_err=stp_flag, all for exactly one cycle.
  - State returns to IDLE in that same cycle.
  - p_data holds until the next frame_start.
  - par_flag is 0 in no-parity modes.
- Latency: 1 clk from the last sample_valid to the status pulses.
- frame_start while busy: the current frame is aborted silently (no pulses, no counting) and a new frame starts, with config re-latched.
- frame_start and sample_valid in the same cycle: frame_start wins; the sample is dropped.
- Counters:
  - Each counter increments on its error pulse and saturates at all-ones; no wrap.
  - err_clr alone sets the counter to 0.
  - err_clr coincident with an increment sets the counter to 1.

Optional Feature:
- Macro: UART_RX_STICKY_STATUS_EN.
- Defined:
  - Adds outputs sticky_par_err and sticky_stp_err (1 bit each, reset 0).
  - Each is set by its error pulse and cleared by err_clr; set wins when both occur in the same cycle.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package uart_rx_pkg holds:
  - par_mode constants PAR_NONE/EVEN/ODD/MARK/SPACE.
  - FSM state typedef and encoding.
  - MIN_DATA_BITS = 5.
- Sub-module sat_counter:
  - Parameter WIDTH; inputs inc and clr; output cnt.
  - Implements the clear/increment/saturate rules above.
  - Instantiated twice.

Test Plan:
- 8N1, data 0xA5 LSB first, stop=1 -> p_data=0xA5, data_valid pulse 1 clk after the stop sample, par_err=0, stp_err=0.
- 8E1, data 0x07, parity bit 0 -> par_err=1, par_err_cnt=1; repeat with parity bit 1 -> par_err=0, counter stays 1.
- 5O2, data 0x1F, parity 0, stop bits 1 then 0 -> p_data=0x01F, par_err=0, stp_err=1, stp_err_cnt=1.
- Mark then space modes on the same data with parity bit 1 -> mark frame no error, space frame par_err=1.
- frame_start after 4 data bits, then a full 8N1 frame of 0x3C -> only one data_valid, p_data=0x3C, no counter change.
- CNT_WIDTH=2, 4 parity errors -> par_err_cnt saturates at 3; err_clr on the same cycle as the 5th error -> count 1.
